// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus arbiter: FSM state encoding and the full-word byte-enable constant.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        ERROR = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_wait_timer.sv
// Counts bus wait cycles of the in-flight transfer and flags a stuck slave.
// Latency: timeout is combinational from the count, so it asserts in the cycle that would be the TIMEOUT-th wait.
// Backpressure: none; clr wins over en, and the count saturates rather than wrapping.
module mips_wait_timer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The wait counted at this edge is the TIMEOUT-th one once the count already holds TIMEOUT-1.
    assign timeout = en && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style bus between instruction fetch and data load/store, one transfer at a time.
// Latency: accept -> first bus cycle +1, done pulse 1 cycle after the first waitrequest=0 cycle (min 2).
// Backpressure: honours bus_waitrequest with stable outputs; stalls the core while busy; stuck bus -> sticky ERROR.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_byteen,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        stall,
    output logic        bus_error,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        data_done_q, data_done_d;
    logic        busy;
    logic        timer_clr;
    logic        timer_en;
    logic        timeout;

    assign busy     = (state_q == FETCH) || (state_q == DATA);
    assign timer_en = busy && bus_waitrequest;

    mips_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .timeout (timeout)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        wr_d          = wr_q;
        instr_d       = instr_q;
        rdata_d       = rdata_q;
        fetch_valid_d = 1'b0;
        data_done_d   = 1'b0;
        timer_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                // Data beats fetch: it belongs to the instruction already in flight in the core.
                if (clk_enable && (data_read || data_write)) begin
                    state_d   = DATA;
                    addr_d    = data_addr;
                    be_d      = data_byteen;
                    wdata_d   = data_wdata;
                    wr_d      = data_write;
                    timer_clr = 1'b1;
                end else if (clk_enable && fetch_req) begin
                    state_d   = FETCH;
                    addr_d    = fetch_addr;
                    be_d      = BE_WORD;
                    wdata_d   = '0;
                    wr_d      = 1'b0;
                    timer_clr = 1'b1;
                end
            end
            FETCH, DATA: begin
                if (!bus_waitrequest) begin
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        instr_d       = bus_readdata;
                        fetch_valid_d = 1'b1;
                    end else begin
                        if (!wr_q) begin
                            rdata_d = bus_readdata;
                        end
                        data_done_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            instr_q       <= '0;
            rdata_q       <= '0;
            fetch_valid_q <= 1'b0;
            data_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            instr_q       <= instr_d;
            rdata_q       <= rdata_d;
            fetch_valid_q <= fetch_valid_d;
            data_done_q   <= data_done_d;
        end
    end

    // Strobes decode the state register directly so reset removes them without waiting for an edge.
    assign bus_read       = (state_q == FETCH) || ((state_q == DATA) && !wr_q);
    assign bus_write      = (state_q == DATA) && wr_q;
    assign bus_address    = busy ? addr_q : '0;
    assign bus_byteenable = busy ? be_q : '0;
    assign bus_writedata  = bus_write ? wdata_q : '0;

    assign fetch_valid = fetch_valid_q;
    assign data_done   = data_done_q;
    assign instr_out   = instr_q;
    assign data_rdata  = rdata_q;
    assign bus_error   = (state_q == ERROR);
    assign stall       = reset && ((state_q != IDLE) ||
                                   (clk_enable && (fetch_req || data_read || data_write)));

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: inputs driven and outputs sampled on the falling clock edge.
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] instr_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_byteen;
    logic [31:0] data_wdata;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        stall;
    logic        bus_error;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;

    int n_cmp;
    int n_fail;

    mips_bus_arbiter #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_valid     (fetch_valid),
        .instr_out       (instr_out),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_addr       (data_addr),
        .data_byteen     (data_byteen),
        .data_wdata      (data_wdata),
        .data_done       (data_done),
        .data_rdata      (data_rdata),
        .stall           (stall),
        .bus_error       (bus_error),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_byteenable  (bus_byteenable),
        .bus_writedata   (bus_writedata),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; clk_enable = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        data_read = 1'b0; data_write = 1'b0; data_addr = '0; data_byteen = '0; data_wdata = '0;
        bus_waitrequest = 1'b0; bus_readdata = '0;
        #1;
        n_cmp++; if ({bus_read, bus_write, fetch_valid, data_done, stall, bus_error} !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 000000", {bus_read, bus_write, fetch_valid, data_done, stall, bus_error}); end
        n_cmp++; if ({instr_out, data_rdata, bus_address, bus_writedata} !== 128'b0) begin n_fail++; $display("FAIL rst_data: instr %h rdata %h addr %h wdata %h want all 0", instr_out, data_rdata, bus_address, bus_writedata); end
        n_cmp++; if (bus_byteenable !== 4'b0) begin n_fail++; $display("FAIL rst_be: got %b want 0000", bus_byteenable); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_write, stall} !== 3'b0) begin n_fail++; $display("FAIL idle_after_rst: got %b want 000", {bus_read, bus_write, stall}); end
    endtask

    task automatic test_fetch();
        fetch_addr = 32'hBFC0_0000; fetch_req = 1'b1; bus_waitrequest = 1'b0; bus_readdata = 32'h8C22_0004;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_req: got %b want 1", stall); end
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_write, fetch_valid} !== 3'b100) begin n_fail++; $display("FAIL fetch_strobe: rd/wr/fv %b want 100", {bus_read, bus_write, fetch_valid}); end
        n_cmp++; if (bus_address !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_addr: got %h want bfc00000", bus_address); end
        n_cmp++; if (bus_byteenable !== 4'b1111) begin n_fail++; $display("FAIL fetch_be: got %b want 1111", bus_byteenable); end
        @(negedge clk);
        n_cmp++; if ({fetch_valid, bus_read} !== 2'b10) begin n_fail++; $display("FAIL fetch_done: fv/rd %b want 10", {fetch_valid, bus_read}); end
        n_cmp++; if (instr_out !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_instr: got %h want 8c220004", instr_out); end
        fetch_req = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_done: got %b want 0", stall); end
        bus_readdata = 32'h1111_1111;
        @(negedge clk);
        n_cmp++; if ({fetch_valid, bus_read} !== 2'b00) begin n_fail++; $display("FAIL fetch_pulse_end: fv/rd %b want 00", {fetch_valid, bus_read}); end
        n_cmp++; if (instr_out !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_hold: got %h want 8c220004", instr_out); end
    endtask

    task automatic test_store_wait();
        int done_cnt;
        done_cnt = 0;
        data_write = 1'b1; data_addr = 32'h1000_0010; data_byteen = 4'b0011; data_wdata = 32'h1234_ABCD;
        bus_waitrequest = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if ({bus_write, bus_read, data_done} !== 3'b100) begin n_fail++; $display("FAIL store_strobe_c%0d: wr/rd/dd %b want 100", k, {bus_write, bus_read, data_done}); end
            n_cmp++; if ({bus_address, bus_byteenable, bus_writedata} !== {32'h1000_0010, 4'b0011, 32'h1234_ABCD}) begin n_fail++; $display("FAIL store_stable_c%0d: addr %h be %b wdata %h want 10000010 0011 1234abcd", k, bus_address, bus_byteenable, bus_writedata); end
            if (k == 1) begin
                data_addr = 32'hFFFF_0000; data_byteen = 4'b1111; data_wdata = 32'h0;
            end
            bus_waitrequest = (k < 4);
            @(negedge clk);
            if (data_done === 1'b1) done_cnt++;
        end
        n_cmp++; if ({data_done, bus_write} !== 2'b10) begin n_fail++; $display("FAIL store_done: dd/wr %b want 10", {data_done, bus_write}); end
        n_cmp++; if (data_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", data_rdata); end
        data_write = 1'b0;
        @(negedge clk);
        if (data_done === 1'b1) done_cnt++;
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL store_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_end: got %b want 0", stall); end
    endtask

    task automatic test_priority();
        data_read = 1'b1; data_addr = 32'h0000_2000; data_byteen = 4'b0100;
        fetch_req = 1'b1; fetch_addr = 32'h0040_0004;
        bus_waitrequest = 1'b0; bus_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_address, bus_byteenable} !== {1'b1, 32'h0000_2000, 4'b0100}) begin n_fail++; $display("FAIL prio_data_first: rd %b addr %h be %b want 1 00002000 0100", bus_read, bus_address, bus_byteenable); end
        @(negedge clk);
        n_cmp++; if ({data_done, fetch_valid} !== 2'b10) begin n_fail++; $display("FAIL prio_dd: dd/fv %b want 10", {data_done, fetch_valid}); end
        n_cmp++; if (data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_rdata: got %h want deadbeef", data_rdata); end
        data_read = 1'b0; bus_readdata = 32'h2402_0001;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL prio_stall_pending: got %b want 1", stall); end
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_address, bus_byteenable} !== {1'b1, 32'h0040_0004, 4'b1111}) begin n_fail++; $display("FAIL prio_fetch_next: rd %b addr %h be %b want 1 00400004 1111", bus_read, bus_address, bus_byteenable); end
        @(negedge clk);
        n_cmp++; if ({fetch_valid, instr_out} !== {1'b1, 32'h2402_0001}) begin n_fail++; $display("FAIL prio_fetch_done: fv %b instr %h want 1 24020001", fetch_valid, instr_out); end
        n_cmp++; if (data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_rdata_hold: got %h want deadbeef", data_rdata); end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clk_enable();
        data_read = 1'b1; data_addr = 32'h0000_3000; data_byteen = 4'b1111;
        bus_waitrequest = 1'b1; bus_readdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_address} !== {1'b1, 32'h0000_3000}) begin n_fail++; $display("FAIL ce_data_start: rd %b addr %h want 1 00003000", bus_read, bus_address); end
        clk_enable = 1'b0; data_read = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0040_0008;
        @(negedge clk);
        n_cmp++; if ({bus_read, stall} !== 2'b11) begin n_fail++; $display("FAIL ce_data_cont: rd/stall %b want 11", {bus_read, stall}); end
        bus_waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++; if ({data_done, bus_read, stall} !== 3'b100) begin n_fail++; $display("FAIL ce_data_done: dd/rd/stall %b want 100", {data_done, bus_read, stall}); end
        n_cmp++; if (data_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ce_rdata: got %h want cafef00d", data_rdata); end
        bus_readdata = 32'h0000_0020;
        @(negedge clk);
        n_cmp++; if ({bus_read, fetch_valid} !== 2'b00) begin n_fail++; $display("FAIL ce_blocked: rd/fv %b want 00", {bus_read, fetch_valid}); end
        clk_enable = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ce_stall_en: got %b want 1", stall); end
        @(negedge clk);
        n_cmp++; if ({bus_read, bus_address} !== {1'b1, 32'h0040_0008}) begin n_fail++; $display("FAIL ce_fetch_launch: rd %b addr %h want 1 00400008", bus_read, bus_address); end
        @(negedge clk);
        n_cmp++; if ({fetch_valid, instr_out} !== {1'b1, 32'h0000_0020}) begin n_fail++; $display("FAIL ce_fetch_done: fv %b instr %h want 1 00000020", fetch_valid, instr_out); end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        fetch_req = 1'b1; fetch_addr = 32'h0040_0010; bus_waitrequest = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if ({bus_read, bus_error} !== 2'b10) begin n_fail++; $display("FAIL to_wait_c%0d: rd/err %b want 10", k, {bus_read, bus_error}); end
            if (k == 1) fetch_req = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if ({bus_error, bus_read, bus_write, stall} !== 4'b1001) begin n_fail++; $display("FAIL to_error: err/rd/wr/stall %b want 1001", {bus_error, bus_read, bus_write, stall}); end
        bus_waitrequest = 1'b0; fetch_req = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus_error, bus_read, fetch_valid, stall} !== 4'b1001) begin n_fail++; $display("FAIL to_sticky: err/rd/fv/stall %b want 1001", {bus_error, bus_read, fetch_valid, stall}); end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_clears_err: got %b want 0", bus_error); end
        @(negedge clk); reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h0040_0014; bus_waitrequest = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_read !== 1'b1) begin n_fail++; $display("FAIL midrst_active: rd %b want 1", bus_read); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({bus_read, bus_write, stall, bus_error, fetch_valid, data_done} !== 6'b0) begin n_fail++; $display("FAIL midrst_flags: got %b want 000000", {bus_read, bus_write, stall, bus_error, fetch_valid, data_done}); end
        n_cmp++; if ({bus_address, bus_byteenable, bus_writedata} !== 68'b0) begin n_fail++; $display("FAIL midrst_bus: addr %h be %b wdata %h want 0", bus_address, bus_byteenable, bus_writedata); end
        n_cmp++; if ({instr_out, data_rdata} !== 64'b0) begin n_fail++; $display("FAIL midrst_hold_regs: instr %h rdata %h want 0", instr_out, data_rdata); end
        fetch_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus_read, stall} !== 2'b00) begin n_fail++; $display("FAIL midrst_after: rd/stall %b want 00", {bus_read, stall}); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_fetch();
        test_store_wait();
        test_priority();
        test_clk_enable();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
